// File: rtl/lsu_controller.sv
// Load/store sequencer: IDLE/REQ/DONE/ERR FSM that drives a req/ack data-memory port,
// generates strobes and replicated store data, and extends load data.
module lsu_controller #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            store_i,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            misaligned,
  output logic            illegal,
  output logic            bus_timeout,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic            r_we;
  logic [3:0]      r_strb;
  logic [31:0]     r_wdata;
  logic [31:0]     r_ldata;
  logic            r_is_load;
  logic [2:0]      r_fun3;
  logic [1:0]      r_off;

  logic            w_access;
  logic            w_ill;
  logic            w_mis;
  logic            w_idle;
  logic            w_launch;
  logic            w_tmo;
  logic [3:0]      w_strb;
  logic [31:0]     w_wdata;
  logic [31:0]     w_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ext;

  assign w_access = load_i | store_i;
  assign w_idle   = (r_state == S_IDLE);

  always_comb begin
    w_ill = 1'b0;
    if (load_i && store_i)
      w_ill = 1'b1;
    else if (load_i)
      w_ill = (fun3 == 3'b011) || (fun3 == 3'b111);
    else if (store_i)
      w_ill = fun3[2] || (fun3[1:0] == 2'b11);
  end

  // Alignment is only meaningful once the width code itself is legal.
  assign w_mis = !w_ill && (((fun3[1:0] == 2'b01) && addr[0]) ||
                            ((fun3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));

  assign w_launch   = w_idle && w_access && !w_ill && !w_mis;
  assign illegal    = w_idle && w_access && w_ill;
  assign misaligned = w_idle && w_access && w_mis;
  assign stall      = w_launch || (r_state == S_REQ);
  assign dmem_req   = (r_state == S_REQ);
  assign load_valid = (r_state == S_DONE) && r_is_load;
  assign bus_timeout = (r_state == S_ERR);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_wstrb = r_strb;
  assign load_data  = r_ldata;
  assign w_tmo      = (TIMEOUT != 0) && (r_cnt == LAST);

  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = store_data;
    case (fun3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << addr[1:0];
        w_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = dmem_rdata >> {r_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_ext = dmem_rdata;
    case (r_fun3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_strb    <= 4'b0000;
      r_wdata   <= '0;
      r_ldata   <= '0;
      r_is_load <= 1'b0;
      r_fun3    <= 3'b000;
      r_off     <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_launch) begin
            r_addr    <= {addr[31:2], 2'b00};
            r_we      <= store_i;
            r_strb    <= store_i ? w_strb : 4'b0000;
            r_wdata   <= store_i ? w_wdata : 32'd0;
            r_is_load <= load_i;
            r_fun3    <= fun3;
            r_off     <= addr[1:0];
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack on the final allowed cycle still completes the access.
          if (dmem_ack) begin
            if (r_is_load)
              r_ldata <= w_ext;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_state <= S_ERR;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Randomized bench for lsu_controller: transaction-level model predicts each cycle's outputs.
module tb_lsu_controller;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic        store_i = 1'b0;
  logic [2:0]  fun3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        illegal;
  logic        bus_timeout;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int n_chk = 0;
  int n_err = 0;

  int          stall_cnt, req_cnt;
  logic [31:0] cap_ldata, cap_addr, cap_wdata;
  logic [3:0]  cap_strb;
  bit          cap_mis, cap_ill, saw_tmo, saw_lv;

  always #5 clk = ~clk;

  lsu_controller #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .store_i(store_i), .fun3(fun3),
    .addr(addr), .store_data(store_data), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .misaligned(misaligned), .illegal(illegal),
    .bus_timeout(bus_timeout), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit f_ill(bit ld, bit st, logic [2:0] f);
    if (ld && st) return 1'b1;
    if (ld) return !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6});
    if (st) return !(f inside {3'd0, 3'd1, 3'd2});
    return 1'b0;
  endfunction

  function automatic bit f_mis(bit ld, bit st, logic [2:0] f, logic [31:0] a);
    int bytes;
    if (f_ill(ld, st, f)) return 1'b0;
    bytes = 1 << f[1:0];
    return (a % bytes) != 0;
  endfunction

  function automatic logic [3:0] f_strb(logic [2:0] f, logic [31:0] a);
    int bytes;
    int mask;
    bytes = 1 << f[1:0];
    mask  = (1 << bytes) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] f_wdata(logic [2:0] f, logic [31:0] sd);
    case (f[1:0])
      2'b00:   return (sd & 32'hFF) * 32'h01010101;
      2'b01:   return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(logic [2:0] f, logic [31:0] a, logic [31:0] rd);
    logic [31:0] v;
    v = rd >> ((a % 4) * 8);
    case (f[1:0])
      2'b00: begin
        v = v & 32'hFF;
        if (!f[2] && v >= 32'd128) v = v | 32'hFFFFFF00;
      end
      2'b01: begin
        v = v & 32'hFFFF;
        if (!f[2] && v >= 32'd32768) v = v | 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    load_i = 1'b0; store_i = 1'b0;
    dmem_ack = ($urandom_range(0, 3) == 0);
    dmem_rdata = $urandom;
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_req", dmem_req, 0);
    chk("idle_lv", load_valid, 0);
    chk("idle_flags", {misaligned, illegal, bus_timeout}, 0);
  endtask

  // ackd: REQ-cycle index (0-based) on which ack is given, -1 for never.
  task automatic run(input bit ld, input bit st, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] sd, input int ackd, input logic [31:0] rd);
    bit ill, mis, ok;
    int k;
    stall_cnt = 0; req_cnt = 0; saw_tmo = 0; saw_lv = 0;
    @(negedge clk);
    load_i = ld; store_i = st; fun3 = f; addr = a; store_data = sd;
    dmem_ack = ($urandom_range(0, 3) == 0);
    dmem_rdata = $urandom;
    #1;
    ill = f_ill(ld, st, f);
    mis = f_mis(ld, st, f, a);
    cap_ill = illegal; cap_mis = misaligned;
    chk("launch_illegal", illegal, ill);
    chk("launch_misaligned", misaligned, mis);
    chk("launch_stall", stall, !(ill || mis));
    chk("launch_req", dmem_req, 0);
    chk("launch_lv_tmo", {load_valid, bus_timeout}, 0);
    stall_cnt += stall;
    if (ill || mis) return;
    k = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      dmem_ack = (k == ackd);
      dmem_rdata = dmem_ack ? rd : $urandom;
      #1;
      chk("req_req", dmem_req, 1);
      chk("req_stall", stall, 1);
      chk("req_we", dmem_we, st);
      chk("req_addr", dmem_addr, {a[31:2], 2'b00});
      chk("req_strb", dmem_wstrb, st ? f_strb(f, a) : 4'b0000);
      if (st) chk("req_wdata", dmem_wdata, f_wdata(f, sd));
      chk("req_lv_tmo", {load_valid, bus_timeout}, 0);
      stall_cnt += stall;
      req_cnt += dmem_req;
      cap_addr = dmem_addr; cap_strb = dmem_wstrb; cap_wdata = dmem_wdata;
      if (k == ackd) begin ok = 1'b1; break; end
      if (k == TMO - 1) break;
      k++;
    end
    @(negedge clk);
    dmem_ack = $urandom_range(0, 1);
    dmem_rdata = $urandom;
    #1;
    chk("end_stall", stall, 0);
    chk("end_req", dmem_req, 0);
    chk("end_lv", load_valid, ok && ld);
    chk("end_tmo", bus_timeout, !ok);
    chk("end_flags", {misaligned, illegal}, 0);
    if (ok && ld) chk("end_ldata", load_data, f_load(f, a, rd));
    cap_ldata = load_data;
    saw_tmo = bus_timeout;
    saw_lv = load_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_outputs", {stall, load_valid, misaligned, illegal, bus_timeout, dmem_req, dmem_we}, 0);
    chk("rst_ldata", load_data, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF);
    chk("t1_ldata", cap_ldata, 32'hDEADBEEF);
    chk("t1_stall_cycles", stall_cnt, 2);
    chk("t1_lv", saw_lv, 1);

    run(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0);
    chk("t2_addr", cap_addr, 32'h200);
    chk("t2_strb", cap_strb, 4'b1000);
    chk("t2_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("t2_lv", saw_lv, 0);

    run(1, 0, 3'b001, 32'h102, 0, 2, 32'h80FF1234);
    chk("t3_lh", cap_ldata, 32'hFFFF80FF);
    run(1, 0, 3'b101, 32'h102, 0, 1, 32'h80FF1234);
    chk("t3_lhu", cap_ldata, 32'h000080FF);
    run(1, 0, 3'b000, 32'h101, 0, 0, 32'h80FF1234);
    chk("t3_lb", cap_ldata, 32'h00000012);

    run(1, 0, 3'b010, 32'h102, 0, 0, 0);
    chk("t4_mis", cap_mis, 1);
    chk("t4_mis_noreq", req_cnt, 0);
    run(1, 0, 3'b011, 32'h100, 0, 0, 0);
    chk("t4_ill", cap_ill, 1);
    chk("t4_ill_noreq", req_cnt, 0);

    run(1, 0, 3'b010, 32'h400, 0, -1, 0);
    chk("t5_req_cycles", req_cnt, 16);
    chk("t5_tmo", saw_tmo, 1);
    idle_cycle();
    run(1, 0, 3'b010, 32'h404, 0, 15, 32'h12345678);
    chk("t5b_req_cycles", req_cnt, 16);
    chk("t5b_tmo", saw_tmo, 0);
    chk("t5b_ldata", cap_ldata, 32'h12345678);

    @(negedge clk);
    load_i = 1'b1; store_i = 1'b0; fun3 = 3'b010; addr = 32'h300; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_req_before", dmem_req, 1);
    load_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_req_async", dmem_req, 0);
    chk("t6_stall_async", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    #1;
    chk("t6_late_ack_req", dmem_req, 0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("t6_late_ack_lv", {load_valid, bus_timeout, stall}, 0);
    run(1, 0, 3'b010, 32'h308, 0, 1, 32'hCAFEF00D);
    chk("t6_after_rst", cap_ldata, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      int r, sel, ackd;
      bit ld, st;
      logic [2:0]  f;
      logic [31:0] a;
      sel = $urandom_range(0, 15);
      ld = (sel == 0) || (sel >= 1 && sel <= 7);
      st = (sel == 0) || (sel >= 8 && sel <= 14);
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = $urandom_range(0, 15);
      if (r < 2) ackd = -1;
      else if (r < 4) ackd = $urandom_range(13, 15);
      else ackd = $urandom_range(0, 4);
      if (sel == 15) idle_cycle();
      else run(ld, st, f, a, $urandom, ackd, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
